// File: rtl/unpooler_if.sv
// Stream bundle for the unpooler: pooled input handshake plus the upsampled
// output stream (data_out / valid_op / end_op).
interface unpooler_if #(
  parameter int DW = 32
);
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_in;
  logic [DW-1:0] data_out;
  logic          valid_op;
  logic          end_op;

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_in,
    output data_out,
    output valid_op,
    output end_op
  );

  modport master (
    output data_in,
    output valid_in,
    input  ready_in,
    input  data_out,
    input  valid_op,
    input  end_op
  );
endinterface : unpooler_if

// File: rtl/unpooler.sv
// Nearest-neighbour upsampler: buffers one pooled row of N values, then emits it
// P times with every value replicated P times, producing an M x M raster map.
module unpooler #(
  parameter int M  = 4,
  parameter int P  = 2,
  parameter int DW = 32
) (
  input  logic        clk,
  input  logic        master_rst_n,
  input  logic        ce,
  unpooler_if.slave   bus
);

  localparam int N  = M / P;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  localparam logic [NW-1:0] N_LAST = NW'(N - 1);
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);
  localparam logic [NW-1:0] N_ZERO = NW'(0);
  localparam logic [PW-1:0] P_ZERO = PW'(0);
  localparam logic [NW-1:0] N_ONE  = NW'(1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] fcol_q, fcol_d;
  logic [NW-1:0] bcol_q, bcol_d;
  logic [PW-1:0] csub_q, csub_d;
  logic [PW-1:0] sub_q, sub_d;
  logic [NW-1:0] prow_q, prow_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          valid_op_q, valid_op_d;
  logic          end_op_q, end_op_d;
  logic [DW-1:0] rowbuf [N];

  logic accept_s;
  logic col_wrap_s;
  logic row_done_s;
  logic map_done_s;

  // The output column is tracked as (bcol, csub) so bcol == ocol / P without a divider.
  assign accept_s   = ce && bus.valid_in && (state_q == FILL);
  assign col_wrap_s = (bcol_q == N_LAST) && (csub_q == P_LAST);
  assign row_done_s = col_wrap_s && (sub_q == P_LAST);
  assign map_done_s = row_done_s && (prow_q == N_LAST);

  assign bus.ready_in = (state_q == FILL);
  assign bus.data_out = data_out_q;
  assign bus.valid_op = valid_op_q;
  assign bus.end_op   = end_op_q;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      state_q    <= FILL;
      fcol_q     <= N_ZERO;
      bcol_q     <= N_ZERO;
      csub_q     <= P_ZERO;
      sub_q      <= P_ZERO;
      prow_q     <= N_ZERO;
      data_out_q <= {DW{1'b0}};
      valid_op_q <= 1'b0;
      end_op_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcol_q     <= fcol_d;
      bcol_q     <= bcol_d;
      csub_q     <= csub_d;
      sub_q      <= sub_d;
      prow_q     <= prow_d;
      data_out_q <= data_out_d;
      valid_op_q <= valid_op_d;
      end_op_q   <= end_op_d;
    end
  end

  // Row buffer: written only on accepted words; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      rowbuf[fcol_q] <= bus.data_in;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (accept_s && (fcol_q == N_LAST)) begin
          state_d = EMIT;
        end else begin
          state_d = FILL;
        end
      end
      EMIT: begin
        if (ce && row_done_s) begin
          state_d = FILL;
        end else begin
          state_d = EMIT;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Counter and output logic; valid_op/end_op default low so a ce-low edge clears them.
  always_comb begin
    fcol_d     = fcol_q;
    bcol_d     = bcol_q;
    csub_d     = csub_q;
    sub_d      = sub_q;
    prow_d     = prow_q;
    data_out_d = data_out_q;
    valid_op_d = 1'b0;
    end_op_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (accept_s) begin
          fcol_d = (fcol_q == N_LAST) ? N_ZERO : (fcol_q + N_ONE);
        end else begin
          fcol_d = fcol_q;
        end
      end
      EMIT: begin
        if (ce) begin
          data_out_d = rowbuf[bcol_q];
          valid_op_d = 1'b1;
          end_op_d   = map_done_s;
          if (csub_q == P_LAST) begin
            csub_d = P_ZERO;
            bcol_d = (bcol_q == N_LAST) ? N_ZERO : (bcol_q + N_ONE);
          end else begin
            csub_d = csub_q + P_ONE;
            bcol_d = bcol_q;
          end
          if (col_wrap_s) begin
            sub_d = (sub_q == P_LAST) ? P_ZERO : (sub_q + P_ONE);
          end else begin
            sub_d = sub_q;
          end
          if (row_done_s) begin
            prow_d = (prow_q == N_LAST) ? N_ZERO : (prow_q + N_ONE);
          end else begin
            prow_d = prow_q;
          end
        end else begin
          data_out_d = data_out_q;
        end
      end
      default: begin
        fcol_d = N_ZERO;
      end
    endcase
  end

endmodule : unpooler

// File: tb/tb_unpooler.sv
// Directed bench for unpooler: three instances (M4/P2, M6/P3, M4/P1) on one clock,
// output streams captured by a monitor and compared to hand-computed tables.
module tb_unpooler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  ce = 3'b111;
  logic [2:0]  vin = 3'b000;
  logic [31:0] din [3];
  logic [2:0]  rdy;
  logic [2:0]  vop;
  logic [2:0]  eop;
  logic [31:0] dout [3];

  int errors = 0;
  int checks = 0;

  int          cyc = 0;
  int          ocnt [3] = '{0, 0, 0};
  int          ecnt [3] = '{0, 0, 0};
  int          rlow [3] = '{0, 0, 0};
  int          bad_end [3] = '{0, 0, 0};
  logic [31:0] obuf [3][256];
  int          ocyc [3][256];
  int          epos [3][16];
  int          base_o [3];
  int          base_e [3];
  int          base_r [3];
  int          expv [64];

  int exp_a [16] = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 3, 3};
  int exp_m6 [36] = '{1, 1, 1, 2, 2, 2,  1, 1, 1, 2, 2, 2,  1, 1, 1, 2, 2, 2,
                      3, 3, 3, 4, 4, 4,  3, 3, 3, 4, 4, 4,  3, 3, 3, 4, 4, 4};

  unpooler_if #(.DW(32)) ifc [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GM = (g == 1) ? 6 : 4;
    localparam int GP = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
    assign ifc[g].data_in  = din[g];
    assign ifc[g].valid_in = vin[g];
    assign rdy[g]  = ifc[g].ready_in;
    assign vop[g]  = ifc[g].valid_op;
    assign eop[g]  = ifc[g].end_op;
    assign dout[g] = ifc[g].data_out;
    unpooler #(.M(GM), .P(GP), .DW(32)) u_dut (
      .clk          (clk),
      .master_rst_n (rst_n),
      .ce           (ce[g]),
      .bus          (ifc[g])
    );
  end

  always #5 clk = ~clk;

  // Output monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc <= cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if (eop[d] && !vop[d]) bad_end[d] <= bad_end[d] + 1;
      if (!rdy[d]) rlow[d] <= rlow[d] + 1;
      if (vop[d]) begin
        if (ocnt[d] < 256) begin
          obuf[d][ocnt[d]] <= dout[d];
          ocyc[d][ocnt[d]] <= cyc;
        end
        if (eop[d]) begin
          if (ecnt[d] < 16) epos[d][ecnt[d]] <= ocnt[d];
          ecnt[d] <= ecnt[d] + 1;
        end
        ocnt[d] <= ocnt[d] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start(input int d);
    base_o[d] = ocnt[d];
    base_e[d] = ecnt[d];
    base_r[d] = rlow[d];
  endtask

  // Present one word; while not ready, valid stays high with junk that must be ignored.
  task automatic send(input int d, input logic [31:0] v);
    int g;
    g = 0;
    @(negedge clk);
    while (!(rdy[d] && ce[d]) && g < 300) begin
      vin[d] = 1'b1;
      din[d] = 32'hDEAD_BEEF;
      @(negedge clk);
      g++;
    end
    if (g >= 300) check("send timeout", g, 0);
    vin[d] = 1'b1;
    din[d] = v;
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    vin[d] = 1'b0;
    din[d] = 32'h0000_0BAD;
  endtask

  task automatic check_outs(input int d, input string tag, input int n, input int n_end);
    int g;
    g = 0;
    while ((ocnt[d] - base_o[d]) < n && g < 3000) begin
      @(negedge clk);
      g++;
    end
    repeat (6) @(negedge clk);
    check({tag, " count"}, ocnt[d] - base_o[d], n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s data[%0d]", tag, i), obuf[d][base_o[d] + i], expv[i]);
    check({tag, " ends"}, ecnt[d] - base_e[d], n_end);
    for (int k = 0; k < n_end; k++)
      check($sformatf("%s endpos[%0d]", tag, k), epos[d][base_e[d] + k] - base_o[d],
            (k + 1) * (n / n_end) - 1);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) din[d] = 32'd0;
    repeat (3) @(negedge clk);
    check("reset ready", rdy[0], 1);
    check("reset valid", vop[0], 0);
    check("reset end", eop[0], 0);
    check("reset data", dout[0], 0);
    rst_n = 1'b1;

    // Basic map with continuous valid.
    start(0);
    for (int i = 0; i < 4; i++) send(0, i);
    idle(0);
    for (int i = 0; i < 16; i++) expv[i] = exp_a[i];
    check_outs(0, "basic", 16, 1);
    check("basic ready low cycles", rlow[0] - base_r[0], 16);

    // Sparse valid: one-cycle gap after every word.
    start(0);
    for (int i = 0; i < 4; i++) begin
      send(0, i);
      idle(0);
    end
    check_outs(0, "sparse", 16, 1);

    // ce low for three edges after the fifth output.
    start(0);
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, i);
        idle(0);
      end
      begin
        int g;
        g = 0;
        while ((ocnt[0] - base_o[0]) < 5 && g < 500) begin
          @(negedge clk);
          g++;
        end
        ce[0] = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
          check("ce low valid", vop[0], 0);
          check("ce low data", dout[0], 0);
        end
        @(negedge clk);
        ce[0] = 1'b1;
      end
    join
    check_outs(0, "cegate", 16, 1);

    // Back-to-back maps A = 0..3, B = 10..13.
    start(0);
    for (int i = 0; i < 4; i++) send(0, i);
    for (int i = 0; i < 4; i++) send(0, 10 + i);
    idle(0);
    for (int i = 0; i < 16; i++) begin
      expv[i]      = exp_a[i];
      expv[16 + i] = exp_a[i] + 10;
    end
    check_outs(0, "b2b", 32, 2);
    check("b2b gap", ocyc[0][base_o[0] + 16] - ocyc[0][base_o[0] + 15], 3);

    // Asynchronous reset mid-EMIT after the sixth output, then a fresh map.
    start(0);
    send(0, 20);
    send(0, 21);
    idle(0);
    begin
      int g;
      g = 0;
      while ((ocnt[0] - base_o[0]) < 6 && g < 500) begin
        @(negedge clk);
        g++;
      end
    end
    check("pre-reset data", dout[0], 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst data", dout[0], 0);
    check("async rst valid", vop[0], 0);
    check("async rst end", eop[0], 0);
    check("async rst ready", rdy[0], 1);
    @(negedge clk);
    rst_n = 1'b1;
    start(0);
    for (int i = 0; i < 4; i++) send(0, 5 + i);
    idle(0);
    for (int i = 0; i < 16; i++) expv[i] = exp_a[i] + 5;
    check_outs(0, "post-reset", 16, 1);

    // M=6, P=3 with input 1..4.
    start(1);
    for (int i = 0; i < 4; i++) send(1, 1 + i);
    idle(1);
    for (int i = 0; i < 36; i++) expv[i] = exp_m6[i];
    check_outs(1, "m6p3", 36, 1);

    // M=4, P=1: pure re-serialisation of 16 values.
    start(2);
    for (int i = 0; i < 16; i++) send(2, 100 + i);
    idle(2);
    for (int i = 0; i < 16; i++) expv[i] = 100 + i;
    check_outs(2, "m4p1", 16, 1);

    for (int d = 0; d < 3; d++)
      check($sformatf("end without valid dut%0d", d), bad_end[d], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_unpooler
